// File: rtl/load_fetch_pkg.sv
// Shared CPU load definitions: size encodings, exception causes, load FSM states
// and small helpers used by load_fetch and the downstream LoadMask.
package load_fetch_pkg;

    localparam logic [1:0] CT_WORD = 2'd0;
    localparam logic [1:0] CT_HALF = 2'd1;
    localparam logic [1:0] CT_BYTE = 2'd2;
    localparam logic [1:0] CT_RSVD = 2'd3;

    localparam logic CAUSE_MISALIGN = 1'b0;
    localparam logic CAUSE_TIMEOUT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // Reserved size behaves as a word, so it shares the word alignment rule.
    function automatic logic is_misaligned(input logic [1:0] ct, input logic [1:0] addr_lo);
        logic result;
        case (ct)
            CT_BYTE: result = 1'b0;
            CT_HALF: result = addr_lo[0];
            default: result = (addr_lo != 2'd0);
        endcase
        return result;
    endfunction

    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w > 4) ? w : 4;
    endfunction

endpackage

// File: rtl/load_fetch_if.sv
// Load request / memory read / result bus between the pipeline, memory and load_fetch.
interface load_fetch_if;

    logic        LOAD_REQ;
    logic [31:0] ADDR;
    logic [1:0]  CT;
    logic        MEM_RD;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_DATA;
    logic        MEM_RDY;
    logic [31:0] MR;
    logic [1:0]  CT_OUT;
    logic        DONE;
    logic        BUSY;
    logic        EXC;
    logic        EXC_CAUSE;

    modport master (
        output LOAD_REQ, ADDR, CT, MEM_DATA, MEM_RDY,
        input  MEM_RD, MEM_ADDR, MR, CT_OUT, DONE, BUSY, EXC, EXC_CAUSE
    );

    modport slave (
        input  LOAD_REQ, ADDR, CT, MEM_DATA, MEM_RDY,
        output MEM_RD, MEM_ADDR, MR, CT_OUT, DONE, BUSY, EXC, EXC_CAUSE
    );

endinterface

// File: rtl/load_fetch_align.sv
// load_align: right-aligns the addressed byte/halfword of a memory word; upper bits
// are zero-filled because sign extension happens later in LoadMask.
module load_align
    import load_fetch_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  ct,
    input  logic [1:0]  addr_lo,
    output logic [31:0] aligned
);

    // Shift selection by load size; halfword ignores addr_lo[0].
    always_comb begin
        aligned = data;
        case (ct)
            CT_BYTE: aligned = data >> {addr_lo, 3'b000};
            CT_HALF: aligned = data >> {addr_lo[1], 4'b0000};
            CT_WORD: aligned = data;
            CT_RSVD: aligned = data;
            default: aligned = data;
        endcase
    end

endmodule

// File: rtl/load_fetch.sv
// load_fetch: load FSM issuing one aligned memory read per request, with timeout.
// Optional build macro MISALIGN_EXC_EN raises a misalignment exception instead of reading.
module load_fetch
    import load_fetch_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
)(
    input  logic         clk,
    input  logic         reset,
    load_fetch_if.slave  bus
);

    localparam int CW = cnt_width(MEM_TIMEOUT);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    state_e       state_r;
    logic [CW-1:0] cnt_r;
    logic [1:0]   ct_r;
    logic [1:0]   addr_lo_r;
    logic [31:0]  mem_addr_r;
    logic         mem_rd_r;
    logic [31:0]  mr_r;
    logic [1:0]   ct_out_r;
    logic         done_r;
    logic         busy_r;
    logic         exc_r;
    logic         exc_cause_r;

    logic [31:0]  aligned_s;
    logic [CW-1:0] cnt_next_s;
    logic         timeout_s;
    logic         misalign_s;

    load_align u_align (
        .data    (bus.MEM_DATA),
        .ct      (ct_r),
        .addr_lo (addr_lo_r),
        .aligned (aligned_s)
    );

    // Timeout and alignment decisions for the FSM.
    always_comb begin
        cnt_next_s = cnt_r + CNT_ONE;
        timeout_s  = (cnt_next_s >= TIMEOUT_VAL);
`ifdef MISALIGN_EXC_EN
        misalign_s = is_misaligned(bus.CT, bus.ADDR[1:0]);
`else
        misalign_s = 1'b0;
`endif
    end

    // Load FSM with all outputs registered; DONE/EXC default low so each is a single pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            ct_r        <= CT_WORD;
            addr_lo_r   <= 2'd0;
            mem_addr_r  <= 32'd0;
            mem_rd_r    <= 1'b0;
            mr_r        <= 32'd0;
            ct_out_r    <= 2'd0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            exc_r       <= 1'b0;
            exc_cause_r <= 1'b0;
        end else begin
            done_r      <= 1'b0;
            exc_r       <= 1'b0;
            exc_cause_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.LOAD_REQ) begin
                        ct_r       <= bus.CT;
                        addr_lo_r  <= bus.ADDR[1:0];
                        mem_addr_r <= {bus.ADDR[31:2], 2'b00};
                        busy_r     <= 1'b1;
                        cnt_r      <= '0;
                        if (misalign_s) begin
                            state_r     <= ST_ERR;
                            mem_rd_r    <= 1'b0;
                            exc_r       <= 1'b1;
                            exc_cause_r <= CAUSE_MISALIGN;
                        end else begin
                            state_r  <= ST_READ;
                            mem_rd_r <= 1'b1;
                        end
                    end else begin
                        mem_rd_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                ST_READ: begin
                    // Data arriving on the timeout edge still completes the load.
                    if (bus.MEM_RDY) begin
                        mr_r     <= aligned_s;
                        ct_out_r <= ct_r;
                        done_r   <= 1'b1;
                        mem_rd_r <= 1'b0;
                        cnt_r    <= '0;
                        state_r  <= ST_RESP;
                    end else if (timeout_s) begin
                        exc_r       <= 1'b1;
                        exc_cause_r <= CAUSE_TIMEOUT;
                        mem_rd_r    <= 1'b0;
                        cnt_r       <= '0;
                        state_r     <= ST_ERR;
                    end else begin
                        cnt_r <= cnt_next_s;
                    end
                end
                ST_RESP: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                ST_ERR: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    mem_rd_r <= 1'b0;
                    busy_r   <= 1'b0;
                    cnt_r    <= '0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.MEM_RD    = mem_rd_r;
    assign bus.MEM_ADDR  = mem_addr_r;
    assign bus.MR        = mr_r;
    assign bus.CT_OUT    = ct_out_r;
    assign bus.DONE      = done_r;
    assign bus.BUSY      = busy_r;
    assign bus.EXC       = exc_r;
    assign bus.EXC_CAUSE = exc_cause_r;

endmodule

// File: tb/tb_load_fetch.sv
// Directed bench for load_fetch: table of load vectors plus hand sequences for
// timeout, misalignment, busy-ignore and reset-abort behaviour.
module tb_load_fetch;
    import load_fetch_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [31:0] last_mr;
    logic [1:0]  last_ct;

    load_fetch_if bus_if ();

    load_fetch #(.MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ct;
        logic [31:0] addr;
        logic [31:0] data;
        int          delay;
        logic [31:0] exp_mr;
        logic [1:0]  exp_ct;
        logic [31:0] exp_maddr;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input vec_t v);
        bus_if.LOAD_REQ = 1'b1;
        bus_if.ADDR     = v.addr;
        bus_if.CT       = v.ct;
        bus_if.MEM_RDY  = 1'b0;
        bus_if.MEM_DATA = 32'hFFFF_FFFF;
        tick();
        bus_if.LOAD_REQ = 1'b0;
        chk("read_mem_rd", {31'd0, bus_if.MEM_RD}, 32'd1);
        chk("read_busy", {31'd0, bus_if.BUSY}, 32'd1);
        chk("read_mem_addr", bus_if.MEM_ADDR, v.exp_maddr);
        chk("read_done", {31'd0, bus_if.DONE}, 32'd0);
        for (int i = 0; i < v.delay; i++) begin
            // Requests while busy must be dropped.
            bus_if.LOAD_REQ = 1'b1;
            bus_if.ADDR     = 32'h0000_0FFF;
            bus_if.CT       = CT_BYTE;
            tick();
            chk("wait_mem_rd", {31'd0, bus_if.MEM_RD}, 32'd1);
            chk("wait_mem_addr", bus_if.MEM_ADDR, v.exp_maddr);
            chk("wait_exc", {31'd0, bus_if.EXC}, 32'd0);
        end
        bus_if.LOAD_REQ = 1'b0;
        bus_if.MEM_RDY  = 1'b1;
        bus_if.MEM_DATA = v.data;
        tick();
        bus_if.MEM_RDY  = 1'b0;
        bus_if.MEM_DATA = 32'hFFFF_FFFF;
        chk("resp_done", {31'd0, bus_if.DONE}, 32'd1);
        chk("resp_exc", {31'd0, bus_if.EXC}, 32'd0);
        chk("resp_mr", bus_if.MR, v.exp_mr);
        chk("resp_ct_out", {30'd0, bus_if.CT_OUT}, {30'd0, v.exp_ct});
        chk("resp_mem_rd", {31'd0, bus_if.MEM_RD}, 32'd0);
        tick();
        chk("idle_done", {31'd0, bus_if.DONE}, 32'd0);
        chk("idle_busy", {31'd0, bus_if.BUSY}, 32'd0);
        chk("idle_mem_rd", {31'd0, bus_if.MEM_RD}, 32'd0);
        last_mr = v.exp_mr;
        last_ct = v.exp_ct;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_rd"}, {31'd0, bus_if.MEM_RD}, 32'd0);
        chk({tag, "_mem_addr"}, bus_if.MEM_ADDR, 32'd0);
        chk({tag, "_mr"}, bus_if.MR, 32'd0);
        chk({tag, "_ct_out"}, {30'd0, bus_if.CT_OUT}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus_if.DONE}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus_if.BUSY}, 32'd0);
        chk({tag, "_exc"}, {31'd0, bus_if.EXC}, 32'd0);
        chk({tag, "_exc_cause"}, {31'd0, bus_if.EXC_CAUSE}, 32'd0);
    endtask

    initial begin
        vec_t hv;
        n_checks = 0;
        n_fail   = 0;
        last_mr  = 32'd0;
        last_ct  = 2'd0;
        reset           = 1'b0;
        bus_if.LOAD_REQ = 1'b0;
        bus_if.ADDR     = 32'd0;
        bus_if.CT       = CT_WORD;
        bus_if.MEM_DATA = 32'd0;
        bus_if.MEM_RDY  = 1'b0;

        vecs[0] = '{CT_WORD, 32'h0000_0100, 32'h8000_0000, 0,  32'h8000_0000, 2'd0, 32'h0000_0100};
        vecs[1] = '{CT_BYTE, 32'h0000_0103, 32'h80AA_BBCC, 0,  32'h0000_0080, 2'd2, 32'h0000_0100};
        vecs[2] = '{CT_BYTE, 32'h0000_0101, 32'h80AA_BBCC, 1,  32'h0080_AABB, 2'd2, 32'h0000_0100};
        vecs[3] = '{CT_HALF, 32'h0000_0102, 32'h8001_1234, 5,  32'h0000_8001, 2'd1, 32'h0000_0100};
        vecs[4] = '{CT_RSVD, 32'h0000_0204, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF, 2'd3, 32'h0000_0204};
        vecs[5] = '{CT_BYTE, 32'h0000_0102, 32'h1122_3344, 2,  32'h0000_1122, 2'd2, 32'h0000_0100};
        vecs[6] = '{CT_WORD, 32'h0000_0010, 32'h0BAD_F00D, 14, 32'h0BAD_F00D, 2'd0, 32'h0000_0010};

        #3;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 7; k++) begin
            run_load(vecs[k]);
        end

        // Timeout: 15 READ cycles without MEM_RDY, then EXC cause 1, MR held.
        bus_if.LOAD_REQ = 1'b1;
        bus_if.ADDR     = 32'h0000_0300;
        bus_if.CT       = CT_WORD;
        tick();
        bus_if.LOAD_REQ = 1'b0;
        chk("to_first_mem_rd", {31'd0, bus_if.MEM_RD}, 32'd1);
        for (int i = 1; i < 15; i++) begin
            tick();
            chk("to_mem_rd", {31'd0, bus_if.MEM_RD}, 32'd1);
            chk("to_exc_early", {31'd0, bus_if.EXC}, 32'd0);
        end
        tick();
        chk("to_exc", {31'd0, bus_if.EXC}, 32'd1);
        chk("to_cause", {31'd0, bus_if.EXC_CAUSE}, 32'd1);
        chk("to_done", {31'd0, bus_if.DONE}, 32'd0);
        chk("to_mem_rd_off", {31'd0, bus_if.MEM_RD}, 32'd0);
        chk("to_mr_held", bus_if.MR, last_mr);
        chk("to_ct_held", {30'd0, bus_if.CT_OUT}, {30'd0, last_ct});
        tick();
        chk("to_exc_pulse", {31'd0, bus_if.EXC}, 32'd0);
        chk("to_idle_busy", {31'd0, bus_if.BUSY}, 32'd0);

        // Halfword at an odd address.
`ifdef MISALIGN_EXC_EN
        bus_if.LOAD_REQ = 1'b1;
        bus_if.ADDR     = 32'h0000_0101;
        bus_if.CT       = CT_HALF;
        bus_if.MEM_DATA = 32'hA5A5_1234;
        tick();
        bus_if.LOAD_REQ = 1'b0;
        chk("mis_exc", {31'd0, bus_if.EXC}, 32'd1);
        chk("mis_cause", {31'd0, bus_if.EXC_CAUSE}, 32'd0);
        chk("mis_mem_rd", {31'd0, bus_if.MEM_RD}, 32'd0);
        chk("mis_mr_held", bus_if.MR, last_mr);
        tick();
        chk("mis_exc_pulse", {31'd0, bus_if.EXC}, 32'd0);
        chk("mis_mem_rd2", {31'd0, bus_if.MEM_RD}, 32'd0);
        chk("mis_busy", {31'd0, bus_if.BUSY}, 32'd0);
`else
        hv = '{CT_HALF, 32'h0000_0101, 32'hA5A5_1234, 0, 32'hA5A5_1234, 2'd1, 32'h0000_0100};
        run_load(hv);
`endif

        // Reset in the middle of READ aborts the access.
        bus_if.LOAD_REQ = 1'b1;
        bus_if.ADDR     = 32'h0000_0400;
        bus_if.CT       = CT_WORD;
        tick();
        bus_if.LOAD_REQ = 1'b0;
        tick();
        tick();
        chk("abort_pre_mem_rd", {31'd0, bus_if.MEM_RD}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        tick();
        tick();
        @(negedge clk);
        reset = 1'b1;
        // MEM_RDY while idle must not produce a response.
        bus_if.MEM_RDY  = 1'b1;
        bus_if.MEM_DATA = 32'hCAFE_0000;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("post_reset_done", {31'd0, bus_if.DONE}, 32'd0);
            chk("post_reset_exc", {31'd0, bus_if.EXC}, 32'd0);
            chk("post_reset_busy", {31'd0, bus_if.BUSY}, 32'd0);
        end
        bus_if.MEM_RDY = 1'b0;
        hv = '{CT_WORD, 32'h0000_0200, 32'h1234_5678, 1, 32'h1234_5678, 2'd0, 32'h0000_0200};
        run_load(hv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_fetch.md
LOAD_FETCH -- requirements
Module: load_fetch

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum READ-state cycles without MEM_RDY before a timeout is raised.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; the design has one clock, and reset asserts immediately and releases synchronously to clk.
REQ-004 LOAD_REQ  input  1  load request, sampled only in IDLE.
REQ-005 ADDR  input  32  byte address of the load.
REQ-006 CT  input  2  load size: 0=word, 1=halfword, 2=byte, 3=reserved (treated as word).
REQ-007 MEM_RD  output  1  memory read strobe.
REQ-008 MEM_ADDR  output  32  word-aligned memory address ({ADDR[31:2],2'b00}).
REQ-009 MEM_DATA  input  32  memory read data, valid when MEM_RDY=1.
REQ-010 MEM_RDY  input  1  memory data-valid handshake.
REQ-011 MR  output  32  registered, right-aligned load data feeding the downstream LoadMask MR input.
REQ-012 CT_OUT  output  2  registered size, paired with MR and feeding the LoadMask CT input.
REQ-013 DONE  output  1  one-cycle pulse: MR/CT_OUT updated.
REQ-014 BUSY  output  1  high in every state except IDLE.
REQ-015 EXC  output  1  one-cycle exception pulse.
REQ-016 EXC_CAUSE  output  1  0=misaligned, 1=timeout; valid only while EXC=1.

Function
REQ-017 FSM states: IDLE, READ, RESP, ERR; encoding 2 bits.
REQ-018 IDLE: LOAD_REQ=1 at an edge latches ADDR and CT; an aligned request goes to READ, a misaligned one (REQ-031) goes to ERR.
REQ-019 READ: MEM_RD=1 and MEM_ADDR holds the latched aligned address for the whole state; MEM_RD=0 in all other states.
REQ-020 READ with MEM_RDY=1 at an edge: capture MR, CT_OUT<=latched CT, go to RESP, clear the timeout counter.
REQ-021 Alignment: MR = MEM_DATA >> (8*ADDR[1:0]) for byte, MEM_DATA >> (16*ADDR[1]) for halfword, MEM_DATA unchanged for word/reserved; vacated upper bits are 0 (sign extension belongs to LoadMask).
REQ-022 RESP: DONE=1 for exactly one cycle, then IDLE; minimum request-to-DONE latency is 2 cycles (MEM_RDY high on the first READ edge).
REQ-023 Timeout counter: 4-bit minimum, width clog2(MEM_TIMEOUT+1); it increments every READ edge with MEM_RDY=0; when it reaches MEM_TIMEOUT the FSM goes to ERR with cause 1.
REQ-024 ERR: EXC=1 for one cycle with the latched cause, MR/CT_OUT unchanged, then IDLE.
REQ-025 LOAD_REQ is ignored whenever BUSY=1; there is no queuing.
REQ-026 MEM_RDY outside READ is ignored.
REQ-027 MEM_RDY and a timeout at the same edge: MEM_RDY wins (capture, no EXC).
REQ-028 DONE and EXC are never high in the same cycle.

Reset
REQ-029 reset=0 forces state IDLE, counter 0, MR=0, CT_OUT=0, DONE=0, EXC=0, EXC_CAUSE=0, MEM_RD=0, MEM_ADDR=0, BUSY=0, regardless of clk.
REQ-030 Reset during READ aborts the access: no DONE and no EXC are produced, and MEM_RD drops asynchronously.

Configuration
REQ-031 Macro MISALIGN_EXC_EN defined: a halfword with ADDR[0]=1, or a word/reserved access with ADDR[1:0]!=0, goes IDLE->ERR with cause 0, and MEM_RD is never asserted for that request.
REQ-032 MISALIGN_EXC_EN undefined: no alignment check; for halfword, ADDR[0] is ignored when shifting; for word, ADDR[1:0] is ignored; EXC_CAUSE 0 never occurs.

Structure
REQ-033 The size encodings (CT_WORD, CT_HALF, CT_BYTE) and FSM state constants live in the shared CPU defines package, which is also used by LoadMask.
REQ-034 One sub-module, load_align, is combinational and maps (MEM_DATA, CT, ADDR[1:0]) to the aligned word; the FSM, counter and registers remain in load_fetch.

Verification
REQ-035 Word load at ADDR=0x100, MEM_DATA=0x80000000, MEM_RDY on the first READ edge -> MEM_ADDR=0x100, MR=0x80000000, CT_OUT=0, DONE 2 cycles after request.
REQ-036 Byte load at ADDR=0x103, MEM_DATA=0x80AABBCC -> MEM_ADDR=0x100, MR=0x00000080, CT_OUT=2, DONE one pulse.
REQ-037 Halfword load at ADDR=0x102, MEM_DATA=0x80011234, MEM_RDY delayed 5 cycles -> MEM_RD held 6 cycles, MR=0x00008001, CT_OUT=1; a LOAD_REQ issued while BUSY is ignored.
REQ-038 With MISALIGN_EXC_EN, halfword at ADDR=0x101 -> EXC=1 with EXC_CAUSE=0 on the cycle after the request, MEM_RD never high, MR unchanged; without the macro -> MR=MEM_DATA>>0, DONE.
REQ-039 MEM_RDY held low and MEM_TIMEOUT=15 -> 15 READ cycles, then EXC=1 with EXC_CAUSE=1, MR unchanged, back in IDLE; a repeat with MEM_RDY rising on the 15th edge -> DONE, no EXC.
REQ-040 reset=0 asserted mid-READ -> all outputs zero immediately; after release, no DONE or EXC appears, and a new word load at 0x200 completes normally.
